// File: rtl/cmsdk_ahb_decode_mux.sv
// AHB-Lite address decoder and slave response multiplexer.
// The address phase is decoded combinationally into one-hot selects, and a data-phase owner register steers the slave responses back to the master.
module cmsdk_ahb_decode_mux #(
  parameter logic [31:0] S0_BASE = 32'h0000_0000,
  parameter logic [31:0] S1_BASE = 32'h2000_0000,
  parameter logic [31:0] S2_BASE = 32'h4000_0000,
  parameter logic [31:0] S3_BASE = 32'h4001_0000,
  parameter logic [31:0] S0_MASK = 32'hE000_0000,
  parameter logic [31:0] S1_MASK = 32'hE000_0000,
  parameter logic [31:0] S2_MASK = 32'hFFFF_0000,
  parameter logic [31:0] S3_MASK = 32'hFFFF_0000,
  parameter logic [3:0]  PORT_EN = 4'b1111
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  output logic        HSEL0,
  output logic        HSEL1,
  output logic        HSEL2,
  output logic        HSEL3,
  output logic        HSELDEF,
  input  logic        HREADYOUT0,
  input  logic        HREADYOUT1,
  input  logic        HREADYOUT2,
  input  logic        HREADYOUT3,
  input  logic        HREADYOUTDEF,
  input  logic        HRESP0,
  input  logic        HRESP1,
  input  logic        HRESP2,
  input  logic        HRESP3,
  input  logic        HRESPDEF,
  input  logic [31:0] HRDATA0,
  input  logic [31:0] HRDATA1,
  input  logic [31:0] HRDATA2,
  input  logic [31:0] HRDATA3,
  output logic        HREADY,
  output logic        HRESP,
  output logic [31:0] HRDATA
);

  logic [3:0] match;
  logic [4:0] dec;
  logic [4:0] dsel_q;
  logic [4:0] dsel_d;
  logic       unused_htrans0;

  // Only HTRANS[1] distinguishes an active transfer from IDLE/BUSY.
  assign unused_htrans0 = HTRANS[0];

  always_comb begin
    match    = '0;
    match[0] = PORT_EN[0] && ((HADDR & S0_MASK) == S0_BASE);
    match[1] = PORT_EN[1] && ((HADDR & S1_MASK) == S1_BASE);
    match[2] = PORT_EN[2] && ((HADDR & S2_MASK) == S2_BASE);
    match[3] = PORT_EN[3] && ((HADDR & S3_MASK) == S3_BASE);
  end

  // Lowest matching index wins; no match routes to the default slave.
  always_comb begin
    dec = '0;
    if (match[0])      dec[0] = 1'b1;
    else if (match[1]) dec[1] = 1'b1;
    else if (match[2]) dec[2] = 1'b1;
    else if (match[3]) dec[3] = 1'b1;
    else               dec[4] = 1'b1;
  end

  assign HSEL0   = dec[0];
  assign HSEL1   = dec[1];
  assign HSEL2   = dec[2];
  assign HSEL3   = dec[3];
  assign HSELDEF = dec[4];

  always_comb begin
    dsel_d = dsel_q;
    if (HREADY) begin
      dsel_d = HTRANS[1] ? dec : '0;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dsel_q <= '0;
    end else begin
      dsel_q <= dsel_d;
    end
  end

  // No owner (idle or reset) answers as a zero-wait OKAY with zero data.
  always_comb begin
    HREADY = 1'b1;
    HRESP  = 1'b0;
    HRDATA = '0;
    case (dsel_q)
      5'b00001: begin
        HREADY = HREADYOUT0;
        HRESP  = HRESP0;
        HRDATA = HRDATA0;
      end
      5'b00010: begin
        HREADY = HREADYOUT1;
        HRESP  = HRESP1;
        HRDATA = HRDATA1;
      end
      5'b00100: begin
        HREADY = HREADYOUT2;
        HRESP  = HRESP2;
        HRDATA = HRDATA2;
      end
      5'b01000: begin
        HREADY = HREADYOUT3;
        HRESP  = HRESP3;
        HRDATA = HRDATA3;
      end
      5'b10000: begin
        HREADY = HREADYOUTDEF;
        HRESP  = HRESPDEF;
      end
      default: ;
    endcase
  end

endmodule
